// File: rtl/dcache_pkg.sv
// Shared types and constants for the N-way data cache.
// Optional build macro DCACHE_MISSCNT_EN adds the MISSCNT state.
// Holds the FSM encoding, the miss sentinel and address-field helpers.
package dcache_pkg;

    localparam logic [31:0] BAD_DATA        = 32'hBAD0BAD0;
    localparam logic [31:0] HITCNT_ADDR_DEF = 32'h3100;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FETCH,
        FLUSH,
        HITCNT,
        DONE
`ifdef DCACHE_MISSCNT_EN
        , MISSCNT
`endif
    } dcache_state_t;

    // Tag width left over after byte, word-select and index bits.
    function automatic int tag_width(input int sets, input int words);
        return 32 - 2 - $clog2(words) - $clog2(sets);
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: updated bits after an access plus current victim.
// Purely combinational, zero latency.
// No handshake; caller decides when the updated bits are stored.
module plru_tree #(
    parameter int WAYS = 2
) (
    input  logic [WAYS-2:0]         bits_i,
    input  logic [$clog2(WAYS)-1:0] access_i,
    output logic [WAYS-2:0]         bits_o,
    output logic [$clog2(WAYS)-1:0] victim_o
);

    localparam int LVL = $clog2(WAYS);

    // Heap-ordered tree, node 1 is the root; slot 0 is padding.
    // A node bit of 0 points the victim towards the lower-numbered half.
    logic [WAYS-1:0] tree_in;
    logic [WAYS-1:0] tree_out;
    logic [LVL-1:0]  node_a;
    logic [LVL-1:0]  node_v;
    logic            unused_root_pad;

    assign tree_in         = {bits_i, 1'b0};
    assign bits_o          = tree_out[WAYS-1:1];
    assign unused_root_pad = tree_out[0];

    // Walk the access path pointing each node away from it; walk the victim path.
    always_comb begin
        tree_out = tree_in;
        node_a   = LVL'(1);
        node_v   = LVL'(1);
        victim_o = '0;
        for (int l = 0; l < LVL; l++) begin
            tree_out[node_a]    = ~access_i[LVL-1-l];
            node_a              = (node_a << 1) | LVL'(access_i[LVL-1-l]);
            victim_o[LVL-1-l]   = tree_in[node_v];
            node_v              = (node_v << 1) | LVL'(tree_in[node_v]);
        end
    end

endmodule

// File: rtl/dcache_nway.sv
// N-way write-back write-allocate L1 data cache; hits answer in the same cycle.
// Misses stall for an optional write-back then a line fill; halt flushes dirty lines.
// Optional DCACHE_MISSCNT_EN also writes the miss count after the hit count.
module dcache_nway
    import dcache_pkg::*;
#(
    parameter int          SETS        = 8,
    parameter int          WAYS        = 2,
    parameter int          WORDS       = 2,
    parameter logic [31:0] HITCNT_ADDR = HITCNT_ADDR_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);

    localparam int WSEL_W = $clog2(WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int TAG_W  = tag_width(SETS, WORDS);
    localparam int OFF    = 2 + WSEL_W;

    typedef logic [WORDS-1:0][31:0] line_t;

    line_t             data_q  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAYS-2:0]   plru_q  [SETS];

    dcache_state_t     state_q, state_d;
    logic [WSEL_W-1:0] cnt_q, cnt_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [IDX_W-1:0]  fset_q, fset_d;
    logic [WAY_W-1:0]  fway_q, fway_d;
    logic [31:0]       hitcnt_q, hitcnt_d;
    logic              miss_seen_q, miss_seen_d;
`ifdef DCACHE_MISSCNT_EN
    logic [31:0]       misscnt_q, misscnt_d;
`endif

    logic [WSEL_W-1:0] a_word;
    logic [IDX_W-1:0]  a_idx;
    logic [TAG_W-1:0]  a_tag;
    logic              unused_addr_bits;
    logic [WAYS-1:0]   hit_vec;
    logic              hit_any, inv_any;
    logic [WAY_W-1:0]  hit_way, inv_way, plru_vic;
    logic [WAYS-2:0]   plru_upd;
    logic              hit_upd, wr_hit, fill_wr, fill_last, flush_adv;

    assign a_word           = dmemaddr[OFF-1:2];
    assign a_idx            = dmemaddr[OFF+IDX_W-1:OFF];
    assign a_tag            = dmemaddr[31:OFF+IDX_W];
    assign unused_addr_bits = ^dmemaddr[1:0];

    // Tag compare across the indexed set and lowest-invalid-way search.
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[a_idx][w] && (tag_q[a_idx][w] == a_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w])           hit_way = WAY_W'(w);
            if (!valid_q[a_idx][w])   inv_way = WAY_W'(w);
        end
        hit_any = (dmemREN || dmemWEN) && (|hit_vec);
        inv_any = ~&valid_q[a_idx];
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits_i   (plru_q[a_idx]),
        .access_i (hit_way),
        .bits_o   (plru_upd),
        .victim_o (plru_vic)
    );

    assign dmemload = dhit ? data_q[a_idx][hit_way][a_word] : BAD_DATA;

    // Next state, counters and bus outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        victim_d    = victim_q;
        fset_d      = fset_q;
        fway_d      = fway_q;
        hitcnt_d    = hitcnt_q;
        miss_seen_d = miss_seen_q;
`ifdef DCACHE_MISSCNT_EN
        misscnt_d   = misscnt_q;
`endif
        dhit      = 1'b0;
        flushed   = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        daddr     = '0;
        dstore    = '0;
        hit_upd   = 1'b0;
        wr_hit    = 1'b0;
        fill_wr   = 1'b0;
        fill_last = 1'b0;
        flush_adv = 1'b0;
        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (dmemREN || dmemWEN) begin
                    if (hit_any) begin
                        dhit    = 1'b1;
                        hit_upd = 1'b1;
                        wr_hit  = dmemWEN;
                        // The retry that completes a miss is not a real hit.
                        if (miss_seen_q) miss_seen_d = 1'b0;
                        else             hitcnt_d    = hitcnt_q + 32'd1;
                    end else begin
                        victim_d    = inv_any ? inv_way : plru_vic;
                        miss_seen_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = (!inv_any && dirty_q[a_idx][plru_vic]) ? WB : FETCH;
`ifdef DCACHE_MISSCNT_EN
                        misscnt_d   = misscnt_q + 32'd1;
`endif
                    end
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = {tag_q[a_idx][victim_q], a_idx, cnt_q, 2'b00};
                dstore = data_q[a_idx][victim_q][cnt_q];
                if (!dwait) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == WSEL_W'(WORDS - 1)) state_d = FETCH;
                end
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = {a_tag, a_idx, cnt_q, 2'b00};
                if (!dwait) begin
                    fill_wr = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == WSEL_W'(WORDS - 1)) begin
                        fill_last = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) begin
                    dWEN   = 1'b1;
                    daddr  = {tag_q[fset_q][fway_q], fset_q, cnt_q, 2'b00};
                    dstore = data_q[fset_q][fway_q][cnt_q];
                    if (!dwait) begin
                        cnt_d     = cnt_q + 1'b1;
                        flush_adv = (cnt_q == WSEL_W'(WORDS - 1));
                    end
                end else begin
                    flush_adv = 1'b1;
                end
                if (flush_adv) begin
                    fway_d = fway_q + 1'b1;
                    if (fway_q == WAY_W'(WAYS - 1)) begin
                        fset_d = fset_q + 1'b1;
                        if (fset_q == IDX_W'(SETS - 1)) state_d = HITCNT;
                    end
                end
            end
            HITCNT: begin
                dWEN   = 1'b1;
                daddr  = HITCNT_ADDR;
                dstore = hitcnt_q;
`ifdef DCACHE_MISSCNT_EN
                if (!dwait) state_d = MISSCNT;
            end
            MISSCNT: begin
                dWEN   = 1'b1;
                daddr  = HITCNT_ADDR + 32'd4;
                dstore = misscnt_q;
`endif
                if (!dwait) state_d = DONE;
            end
            DONE: flushed = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            victim_q    <= '0;
            fset_q      <= '0;
            fway_q      <= '0;
            hitcnt_q    <= '0;
            miss_seen_q <= 1'b0;
`ifdef DCACHE_MISSCNT_EN
            misscnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            victim_q    <= victim_d;
            fset_q      <= fset_d;
            fway_q      <= fway_d;
            hitcnt_q    <= hitcnt_d;
            miss_seen_q <= miss_seen_d;
`ifdef DCACHE_MISSCNT_EN
            misscnt_q   <= misscnt_d;
`endif
        end
    end

    // Line status bits; a line only becomes valid on its last fill word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (hit_upd) plru_q[a_idx] <= plru_upd;
            if (wr_hit)  dirty_q[a_idx][hit_way] <= 1'b1;
            if (fill_last) begin
                valid_q[a_idx][victim_q] <= 1'b1;
                dirty_q[a_idx][victim_q] <= 1'b0;
            end
        end
    end

    // Data and tag arrays carry no reset; validity is tracked above.
    always_ff @(posedge CLK) begin
        if (wr_hit)    data_q[a_idx][hit_way][a_word] <= dmemstore;
        if (fill_wr)   data_q[a_idx][victim_q][cnt_q] <= dload;
        if (fill_last) tag_q[a_idx][victim_q]         <= a_tag;
    end

endmodule

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
- Parametrised successor to the 2-way data cache: N-way set-associative, write-back, write-allocate L1 data cache with configurable sets and block size.
- Uses tree pseudo-LRU replacement, prefers invalid ways on fill, and runs a halt-triggered flush that skips clean lines.
- Sits between the datapath (dmem* request side) and the memory controller (d* bus side) for one CPU.

Parameters:
- SETS, 8, number of sets; power of two, at least 2.
- WAYS, 2, associativity; power of two, 2 to 8.
- WORDS, 2, 32-bit words per block; power of two, at least 2.
- HITCNT_ADDR, 32'h3100, word address where the hit count is stored after the flush.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- halt  in  1  datapath halt request.
- dmemREN  in  1  datapath read request.
- dmemWEN  in  1  datapath write request.
- dmemaddr  in  32  byte address; bits [1:0] ignored.
- dmemstore  in  32  write data.
- dhit  out  1  request satisfied this cycle.
- dmemload  out  32  read data.
- flushed  out  1  flush and stats write complete; held until reset.
- dREN  out  1  memory read strobe.
- dWEN  out  1  memory write strobe.
- daddr  out  32  memory word address.
- dstore  out  32  memory write data.
- dload  in  32  memory read data.
- dwait  in  1  memory busy; low = current word completes this cycle.

Behaviour:
- Address split: OFF = 2 + log2(WORDS) offset bits; word select = addr[OFF-1:2]; index = next log2(SETS) bits; tag = remaining upper bits.
- Reset (async, RST=1) clears all valid, dirty and PLRU bits, counters, hitcount and flush pointers. State goes to IDLE. All outputs go to 0 except dmemload = 32'hBAD0BAD0.
- If dmemREN and dmemWEN are both asserted, the request is a write.
- Hit definition: (REN|WEN) and some way has valid with a tag match. dhit and dmemload are combinational in the same cycle. A miss drives dmemload = 32'hBAD0BAD0.
- Write hit: the word is updated and the line's dirty bit is set at the next edge.
- Any hit updates the set's PLRU bits so the hit way becomes MRU.
- States: IDLE, WB, FETCH, FLUSH, HITCNT, DONE.
- IDLE:
  - halt=1 → FLUSH; halt takes priority over a pending request.
  - Hit → stay in IDLE.
  - Miss → pick victim: lowest-index invalid way, else the PLRU victim. Victim valid and dirty → WB; otherwise → FETCH.
  - The victim way is latched at miss detection.
- WB:
  - Drives dWEN=1, daddr = {victim tag, index, word counter, 2'b00}, dstore = victim word.
  - The word counter advances on each cycle with dwait=0.
  - After word WORDS-1 → FETCH.
- FETCH:
  - Drives dREN=1, daddr = {request tag, index, counter, 2'b00}.
  - dload is written into the victim block when dwait=0.
  - On the last word: tag written, valid=1, dirty=0 → IDLE. The retried request then hits on the following cycle.
- dREN and dWEN are never both high. daddr is held stable while dwait=1.
- Hit counter (32-bit, wraps): increments on a hit in IDLE only when the request was not serviced by a miss. A miss_seen flag is set on leaving IDLE and cleared on the first IDLE hit.
- halt is sampled only in IDLE. An in-progress WB or FETCH completes first.
- FLUSH:
  - Walks set 0..SETS-1, and within each set way 0..WAYS-1.
  - Dirty+valid line: writes all WORDS words, one per dwait=0 cycle.
  - Clean or invalid line: one cycle, no bus activity.
  - After the last set/way → HITCNT.
- HITCNT: dWEN=1, daddr=HITCNT_ADDR, dstore=hitcount; on dwait=0 → DONE.
- DONE: flushed=1, bus idle, dhit=0. Terminal until reset.
- Reset asserted mid-transfer aborts immediately. No partial line becomes valid.

Optional Feature:
- DCACHE_MISSCNT_EN defined: a 32-bit miss counter (increments on each IDLE→WB/FETCH transition). HITCNT is followed by a MISSCNT state writing misscount to HITCNT_ADDR+4, then DONE.
- Undefined: no miss counter, HITCNT goes directly to DONE.

Decomposition:
- Shared package dcache_pkg holds:
  - state enum dcache_state_t;
  - BAD_DATA = 32'hBAD0BAD0;
  - default HITCNT_ADDR;
  - a helper function computing the address field widths.
- Line storage type is declared locally (depends on parameters).
- One natural sub-module, plru_tree (parameter WAYS). Inputs: current PLRU bits, access way. Outputs: updated bits and victim way. Purely combinational, instantiated once for the indexed set.

Test Plan:
- Read 0x40 cold (WAYS=2, WORDS=2): FETCH issues daddr 0x40 then 0x44 (dload 0x11, 0x22). Next cycle dhit=1, dmemload=0x11. Read 0x44 → 0x22 with a same-cycle hit.
- Write 0x80=0xDEAD (miss, same set as 0x40): fills the invalid way 1, then the write hit sets dirty. Read 0xC0 (same set): PLRU victim is way 0 (clean), so no WB.
- Set 2 ways dirty, access a third tag: WB writes the dirty PLRU victim's WORDS words at the old tag address, then FETCH at the new tag. The stalled dwait=1 cycles hold daddr stable.
- Halt after 5 IDLE hits and 3 misses with 2 dirty lines: exactly 2×WORDS flush writes, then 0x3100 ← 5, then flushed=1. With DCACHE_MISSCNT_EN, 0x3104 ← 3.
- Assert RST during the second FETCH word: next cycle state=IDLE, outputs zero, a read of the same address misses.
- WAYS=4, SETS=4, WORDS=4: 5 distinct tags to one set. The victim follows tree-PLRU order; the fill sequence is 4 words per line.
